// File: rtl/jcnt_pkg.sv
// Shared types and helpers for the Johnson step controller.
// jcode() maps a phase index to its Johnson code so cnt can always be rebuilt from pos.
package jcnt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Index p < width fills ones from the MSB down; p >= width drains them from the MSB.
  function automatic logic [31:0] jcode(input int pos, input int width);
    logic [31:0] code;
    code = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        if (pos < width) code[i] = (i >= width - pos);
        else             code[i] = (i < 2 * width - pos);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/jcnt_core.sv
// Phase register: owns pos and the Johnson code derived from it.
// A step always reloads cnt from the new pos, so an illegal code heals on the next step.
module jcnt_core
  import jcnt_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int PW = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] cnt,
  output logic [PW-1:0]    pos
);

  localparam int LAST = 2 * WIDTH - 1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [31:0]      code_full;

  always_comb begin
    pos_d = pos_q;
    if (en) begin
      if (dir == DIR_FWD) pos_d = (pos_q == PW'(LAST)) ? '0 : pos_q + 1'b1;
      else                pos_d = (pos_q == '0) ? PW'(LAST) : pos_q - 1'b1;
    end
    code_full = jcode(int'(pos_d), WIDTH);
    cnt_d     = en ? code_full[WIDTH-1:0] : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pos_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pos_q <= pos_d;
    end
  end

  assign cnt = cnt_q;
  assign pos = pos_q;

endmodule

// File: rtl/jcnt_step_controller.sv
// Command sequencer around jcnt_core: runs cmd_steps Johnson steps, one every DIV clocks.
// Handshake: a command transfers on any edge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
module jcnt_step_controller
  import jcnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 2,
  parameter int STEPW = 8,
  localparam int PW   = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [STEPW-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic [PW-1:0]    pos,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [STEPW-1:0] remaining
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] PRESC_LAST = DW'(DIV - 1);

  state_e           state_q, state_d;
  logic [DW-1:0]    presc_q, presc_d;
  logic [STEPW-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             step_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      rem_q     <= '0;
      dir_q     <= DIR_FWD;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    step_en   = 1'b0;
    case (state_q)
      IDLE: begin
        // abort is deliberately not looked at here; a command offer always wins.
        if (cmd_valid) begin
          if (cmd_steps != '0) begin
            state_d = RUN;
            dir_d   = cmd_dir;
            rem_d   = cmd_steps;
            presc_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          rem_d     = '0;
          presc_d   = '0;
          aborted_d = 1'b1;
        end else if (presc_q == PRESC_LAST) begin
          step_en = 1'b1;
          presc_d = '0;
          rem_d   = rem_q - 1'b1;
          if (rem_q == STEPW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    cmd_ready = (state_q == IDLE);
    done      = done_q;
    aborted   = aborted_q;
    remaining = rem_q;
  end

  jcnt_core #(.WIDTH(WIDTH)) u_core (
    .clk (clk),
    .rst (rst),
    .en  (step_en),
    .dir (dir_q),
    .cnt (cnt),
    .pos (pos)
  );

endmodule

// File: tb/tb_jcnt_step_controller.sv
// Bench for jcnt_step_controller (WIDTH=4, DIV=2, STEPW=8) against a phase-index model.
module tb_jcnt_step_controller;

  localparam int W     = 4;
  localparam int DIV   = 2;
  localparam int STEPW = 8;
  localparam int PW    = 3;
  localparam int NPH   = 2 * W;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [STEPW-1:0] cmd_steps;
  logic             cmd_dir;
  logic             abort;
  logic [W-1:0]     cnt;
  logic [PW-1:0]    pos;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [STEPW-1:0] remaining;

  int n_cmp = 0;
  int n_err = 0;
  int m_pos = 0;

  jcnt_step_controller #(.WIDTH(W), .DIV(DIV), .STEPW(STEPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_dir   (cmd_dir),
    .abort     (abort),
    .cnt       (cnt),
    .pos       (pos),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  // Johnson code for a phase index, from run-length arithmetic.
  function automatic logic [W-1:0] exp_code(input int p);
    int v;
    if (p <= W) v = ((1 << p) - 1) << (W - p);
    else        v = (1 << (NPH - p)) - 1;
    return v[W-1:0];
  endfunction

  function automatic int next_pos(input int p, input bit dir);
    return dir ? (p + NPH - 1) % NPH : (p + 1) % NPH;
  endfunction

  task automatic do_run(input int steps, input bit dir, input string tag);
    logic [18:0] got, want;
    logic [W-1:0] held;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_steps = STEPW'(steps); cmd_dir = dir;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if ({busy, cmd_ready, remaining, cnt} !== {1'b1, 1'b0, STEPW'(steps), exp_code(m_pos)}) begin
      n_err++;
      $display("FAIL %s_accept: got %h want %h", tag, {busy, cmd_ready, remaining, cnt},
               {1'b1, 1'b0, STEPW'(steps), exp_code(m_pos)});
    end
    for (int n = 1; n <= steps; n++) begin
      held = exp_code(m_pos);
      for (int d = 1; d < DIV; d++) begin
        @(negedge clk);
        n_cmp++;
        if ({cnt, done} !== {held, 1'b0}) begin
          n_err++;
          $display("FAIL %s_hold%0d: got %h want %h", tag, n, {cnt, done}, {held, 1'b0});
        end
      end
      @(negedge clk);
      m_pos = next_pos(m_pos, dir);
      got  = {cnt, pos, remaining, busy, done, cmd_ready, aborted};
      want = {exp_code(m_pos), PW'(m_pos), STEPW'(steps - n), (n == steps) ? 4'b0110 : 4'b1000};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s_step%0d: got %h want %h", tag, n, got, want);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, aborted} !== 3'b000) begin
      n_err++;
      $display("FAIL %s_after: got %b want 000", tag, {busy, done, aborted});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_pos = 0;
    n_cmp++;
    if ({cnt, pos, cmd_ready, busy, done, aborted, remaining} !== {4'b0000, 3'd0, 4'b1000, 8'd0}) begin
      n_err++;
      $display("FAIL reset: got %h want %h", {cnt, pos, cmd_ready, busy, done, aborted, remaining},
               {4'b0000, 3'd0, 4'b1000, 8'd0});
    end
    @(negedge clk);
    n_cmp++;
    if ({cnt, busy, done} !== {4'b0000, 2'b00}) begin
      n_err++;
      $display("FAIL idle: got %h want 0", {cnt, busy, done});
    end
  endtask

  task automatic test_wrap_reverse();
    do_run(9, 1'b1, "rev9");
    n_cmp++;
    if ({cnt, pos} !== {4'b0001, 3'd7}) begin
      n_err++;
      $display("FAIL rev9_final: got %h want %h", {cnt, pos}, {4'b0001, 3'd7});
    end
    do_run(1, 1'b0, "fwd1");
  endtask

  task automatic test_forward();
    do_run(3, 1'b0, "fwd3");
    n_cmp++;
    if ({cnt, pos} !== {4'b1110, 3'd3}) begin
      n_err++;
      $display("FAIL fwd3_final: got %h want %h", {cnt, pos}, {4'b1110, 3'd3});
    end
  endtask

  task automatic test_zero_and_back_to_back();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_steps = '0; cmd_dir = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if ({cnt, pos, done, busy, cmd_ready} !== {exp_code(m_pos), PW'(m_pos), 3'b101}) begin
      n_err++;
      $display("FAIL zero_done: got %h want %h", {cnt, pos, done, busy, cmd_ready},
               {exp_code(m_pos), PW'(m_pos), 3'b101});
    end
    @(negedge clk);
    n_cmp++;
    if ({done, cnt} !== {1'b0, exp_code(m_pos)}) begin
      n_err++;
      $display("FAIL zero_pulse: got %h want %h", {done, cnt}, {1'b0, exp_code(m_pos)});
    end
    cmd_valid = 1'b1; cmd_steps = 8'd1; cmd_dir = 1'b0;
    @(negedge clk);
    cmd_steps = 8'd2;
    n_cmp++;
    if ({busy, cmd_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_run1: got %b want 10", {busy, cmd_ready});
    end
    repeat (2) @(negedge clk);
    m_pos = next_pos(m_pos, 1'b0);
    n_cmp++;
    if ({cnt, pos, busy, done, cmd_ready} !== {exp_code(m_pos), PW'(m_pos), 3'b011}) begin
      n_err++;
      $display("FAIL b2b_done1: got %h want %h", {cnt, pos, busy, done, cmd_ready},
               {exp_code(m_pos), PW'(m_pos), 3'b011});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if ({busy, done, remaining} !== {2'b10, 8'd2}) begin
      n_err++;
      $display("FAIL b2b_accept2: got %h want %h", {busy, done, remaining}, {2'b10, 8'd2});
    end
    for (int n = 1; n <= 2; n++) begin
      repeat (DIV) @(negedge clk);
      m_pos = next_pos(m_pos, 1'b0);
      n_cmp++;
      if ({cnt, pos, remaining, done} !== {exp_code(m_pos), PW'(m_pos), STEPW'(2 - n), n == 2}) begin
        n_err++;
        $display("FAIL b2b_step%0d: got %h want %h", n, {cnt, pos, remaining, done},
                 {exp_code(m_pos), PW'(m_pos), STEPW'(2 - n), n == 2});
      end
    end
  endtask

  task automatic test_abort_collision();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_steps = 8'd2; cmd_dir = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (DIV) @(negedge clk);
    m_pos = next_pos(m_pos, 1'b0);
    repeat (DIV - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if ({cnt, pos, aborted, done, busy, cmd_ready, remaining} !==
        {exp_code(m_pos), PW'(m_pos), 4'b1001, 8'd0}) begin
      n_err++;
      $display("FAIL abort_hit: got %h want %h", {cnt, pos, aborted, done, busy, cmd_ready, remaining},
               {exp_code(m_pos), PW'(m_pos), 4'b1001, 8'd0});
    end
    @(negedge clk);
    n_cmp++;
    if ({aborted, done, cnt} !== {2'b00, exp_code(m_pos)}) begin
      n_err++;
      $display("FAIL abort_pulse: got %h want %h", {aborted, done, cnt}, {2'b00, exp_code(m_pos)});
    end
    abort = 1'b1; cmd_valid = 1'b1; cmd_steps = 8'd1; cmd_dir = 1'b1;
    @(negedge clk);
    abort = 1'b0; cmd_valid = 1'b0;
    n_cmp++;
    if ({busy, aborted, remaining} !== {2'b10, 8'd1}) begin
      n_err++;
      $display("FAIL abort_idle: got %h want %h", {busy, aborted, remaining}, {2'b10, 8'd1});
    end
    repeat (DIV) @(negedge clk);
    m_pos = next_pos(m_pos, 1'b1);
    n_cmp++;
    if ({cnt, pos, done, aborted} !== {exp_code(m_pos), PW'(m_pos), 2'b10}) begin
      n_err++;
      $display("FAIL abort_idle_run: got %h want %h", {cnt, pos, done, aborted},
               {exp_code(m_pos), PW'(m_pos), 2'b10});
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_steps = 8'd5; cmd_dir = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    m_pos = next_pos(next_pos(m_pos, 1'b0), 1'b0);
    cmd_valid = 1'b1; cmd_steps = 8'd7;
    n_cmp++;
    if ({cmd_ready, busy, remaining, cnt} !== {2'b01, 8'd3, exp_code(m_pos)}) begin
      n_err++;
      $display("FAIL midrun_ignore: got %h want %h", {cmd_ready, busy, remaining, cnt},
               {2'b01, 8'd3, exp_code(m_pos)});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    m_pos = 0;
    n_cmp++;
    if ({cnt, pos, cmd_ready, busy, done, aborted, remaining} !== {4'b0000, 3'd0, 4'b1000, 8'd0}) begin
      n_err++;
      $display("FAIL midrun_reset: got %h want %h", {cnt, pos, cmd_ready, busy, done, aborted, remaining},
               {4'b0000, 3'd0, 4'b1000, 8'd0});
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, aborted, cnt} !== 7'd0) begin
      n_err++;
      $display("FAIL midrun_after: got %h want 0", {busy, done, aborted, cnt});
    end
  endtask

  task automatic test_random();
    int steps;
    bit dir;
    for (int i = 0; i < 16; i++) begin
      steps = $urandom_range(0, 12);
      dir   = 1'($urandom_range(0, 1));
      if (steps == 0) begin
        @(negedge clk);
        cmd_valid = 1'b1; cmd_steps = '0; cmd_dir = dir;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++;
        if ({cnt, pos, done, busy} !== {exp_code(m_pos), PW'(m_pos), 2'b10}) begin
          n_err++;
          $display("FAIL rand_zero%0d: got %h want %h", i, {cnt, pos, done, busy},
                   {exp_code(m_pos), PW'(m_pos), 2'b10});
        end
      end else begin
        do_run(steps, dir, $sformatf("rand%0d", i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_reverse();
    test_forward();
    test_zero_and_back_to_back();
    test_abort_collision();
    test_reset_midrun();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
